// File: rtl/shiftregister_frame_if.sv
// Pin-side bundle of the framed shift register: serial clock/data in,
// mode and parallel word in, register contents, serial bit and frame status out.
interface shiftregister_frame_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             serialClk;
    logic [1:0]       mode;
    logic [WIDTH-1:0] parallelIn;
    logic             serialIn;
    logic [WIDTH-1:0] parallelOut;
    logic             serialOut;
    logic [CNT_W-1:0] bitCount;
    logic             frameDone;

    modport master (
        output serialClk, mode, parallelIn, serialIn,
        input  parallelOut, serialOut, bitCount, frameDone
    );

    modport slave (
        input  serialClk, mode, parallelIn, serialIn,
        output parallelOut, serialOut, bitCount, frameDone
    );
endinterface

// File: rtl/shiftregister_frame.sv
// Serial/parallel shift register clocked by the system clock; serialClk rising
// edges are detected after synchronisation and counted into WIDTH-bit frames.
module shiftregister_frame #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    shiftregister_frame_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_PLOAD = 2'b11
    } mode_e;

    mode_e            w_mode;
    logic             r_sc1, r_sc2, r_sc3;
    logic             r_si1, r_si2;
    logic             w_shift;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_sout, w_sout_nxt;
    logic             r_done, w_done_nxt;

    assign w_mode  = mode_e'(bus.mode);
    assign w_shift = r_sc2 & ~r_sc3;

    // Synchroniser stage: serialIn rides one flop behind sc so si2 lines up with the event
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sc1 <= 1'b0;
            r_sc2 <= 1'b0;
            r_sc3 <= 1'b0;
            r_si1 <= 1'b0;
            r_si2 <= 1'b0;
        end else begin
            r_sc1 <= bus.serialClk;
            r_sc2 <= r_sc1;
            r_sc3 <= r_sc2;
            r_si1 <= bus.serialIn;
            r_si2 <= r_si1;
        end
    end

    // Shift/load stage: PLOAD wins over a coincident shift event, which is dropped
    always_comb begin
        w_data_nxt = r_data;
        w_cnt_nxt  = r_cnt;
        w_sout_nxt = r_sout;
        w_done_nxt = 1'b0;
        unique case (w_mode)
            MODE_PLOAD: begin
                w_data_nxt = bus.parallelIn;
                w_cnt_nxt  = '0;
            end
            MODE_LEFT, MODE_RIGHT: begin
                if (w_shift) begin
                    if (w_mode == MODE_LEFT) begin
                        w_data_nxt = {r_data[WIDTH-2:0], r_si2};
                    end else begin
                        w_data_nxt = {r_si2, r_data[WIDTH-1:1]};
                    end
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_cnt_nxt  = '0;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                w_sout_nxt = (w_mode == MODE_LEFT) ? w_data_nxt[WIDTH-1] : w_data_nxt[0];
            end
            default: begin
                w_data_nxt = r_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_sout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
            r_sout <= w_sout_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign bus.parallelOut = r_data;
    assign bus.serialOut   = r_sout;
    assign bus.bitCount    = r_cnt;
    assign bus.frameDone   = r_done;
endmodule

// File: tb/tb_shiftregister_frame.sv
// Drives an 8-bit and a 16-bit instance from the same pins and compares both
// every cycle against a shift-count/arithmetic reference model.
module tb_shiftregister_frame;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sclk = 1'b0;
    logic        sin = 1'b0;
    logic [1:0]  mode = 2'b11;
    logic [15:0] pin = 16'hFFFF;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd8 = 0;
    int fd16 = 0;

    // reference state: [0] is the 8-bit instance, [1] the 16-bit one
    int          mw[2] = '{8, 16};
    logic [15:0] m_data[2];
    int          m_shifts[2];
    logic        m_sout[2];
    logic        m_done[2];
    int          ev_due[$];
    logic        ev_bit[$];

    always #5 clk = ~clk;

    shiftregister_frame_if #(.WIDTH(8))  bus8();
    shiftregister_frame_if #(.WIDTH(16)) bus16();

    assign bus8.serialClk  = sclk;
    assign bus8.serialIn   = sin;
    assign bus8.mode       = mode;
    assign bus8.parallelIn = pin[7:0];
    assign bus16.serialClk  = sclk;
    assign bus16.serialIn   = sin;
    assign bus16.mode       = mode;
    assign bus16.parallelIn = pin;

    shiftregister_frame #(.WIDTH(8))  u_dut8  (.clk(clk), .resetN(resetN), .bus(bus8));
    shiftregister_frame #(.WIDTH(16)) u_dut16 (.clk(clk), .resetN(resetN), .bus(bus16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mask_of(input int w);
        return 16'((32'h1 << w) - 1);
    endfunction

    task automatic model_clear();
        ev_due.delete();
        ev_bit.delete();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = '0; m_shifts[i] = 0; m_sout[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic ev, b;
        ev = 1'b0;
        b  = 1'b0;
        if (!resetN) return;
        if (ev_due.size() > 0 && ev_due[0] == cyc) begin
            ev = 1'b1;
            b  = ev_bit[0];
            void'(ev_due.pop_front());
            void'(ev_bit.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (mode == 2'b11) begin
                m_data[i]   = pin & mask_of(mw[i]);
                m_shifts[i] = 0;
            end else if (mode == 2'b01 || mode == 2'b10) begin
                if (ev) begin
                    if (mode == 2'b01) m_data[i] = ((m_data[i] << 1) | 16'(b)) & mask_of(mw[i]);
                    else               m_data[i] = (m_data[i] >> 1) | (16'(b) << (mw[i] - 1));
                    m_shifts[i]++;
                    m_done[i] = (m_shifts[i] % mw[i]) == 0;
                end
                m_sout[i] = (mode == 2'b01) ? m_data[i][mw[i]-1] : m_data[i][0];
            end
        end
    endtask

    task automatic compare();
        chk("po8",   32'(bus8.parallelOut), 32'(m_data[0]));
        chk("so8",   32'(bus8.serialOut),   32'(m_sout[0]));
        chk("cnt8",  32'(bus8.bitCount),    32'(m_shifts[0] % 8));
        chk("fd8",   32'(bus8.frameDone),   32'(m_done[0]));
        chk("po16",  32'(bus16.parallelOut), 32'(m_data[1]));
        chk("so16",  32'(bus16.serialOut),   32'(m_sout[1]));
        chk("cnt16", 32'(bus16.bitCount),    32'(m_shifts[1] % 16));
        chk("fd16",  32'(bus16.frameDone),   32'(m_done[1]));
        if (bus8.frameDone === 1'b1)  fd8++;
        if (bus16.frameDone === 1'b1) fd16++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic rise(input logic b);
        sclk = 1'b1;
        if (resetN) begin
            ev_due.push_back(cyc + 3);
            ev_bit.push_back(b);
        end
    endtask

    task automatic pulse(input logic b, input int hi, input int lo);
        sin = b;
        step();
        rise(b);
        repeat (hi) step();
        sclk = 1'b0;
        repeat (lo) step();
    endtask

    task automatic assert_reset();
        resetN = 1'b0;
        model_clear();
        #1;
        chk("rst_po8",  32'(bus8.parallelOut), 32'h0);
        chk("rst_cnt8", 32'(bus8.bitCount),    32'h0);
        chk("rst_so8",  32'(bus8.serialOut),   32'h0);
        chk("rst_po16", 32'(bus16.parallelOut), 32'h0);
        chk("rst_fd16", 32'(bus16.frameDone),   32'h0);
    endtask

    task automatic release_reset();
        resetN = 1'b1;
        if (sclk) begin
            ev_due.push_back(cyc + 3);
            ev_bit.push_back(sin);
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [1:0] next_mode);
        mode = 2'b11;
        pin  = v;
        step();
        mode = next_mode;
    endtask

    initial begin
        logic [7:0] lbits;
        logic [7:0] rbits;
        lbits = 8'b1011_0010;
        rbits = 8'b0001_0101;
        model_clear();

        // reset held with PLOAD and a toggling serial clock
        repeat (3) pulse(1'b1, 4, 4);
        chk("rst_frames", 32'(fd8 + fd16), 32'h0);
        release_reset();
        step();

        // PLOAD then HOLD: shift events are discarded
        load(16'h00A5, 2'b00);
        fd8 = 0; fd16 = 0;
        repeat (8) pulse(1'b1, 4, 4);
        chk("hold_po8", 32'(bus8.parallelOut), 32'hA5);
        chk("hold_cnt8", 32'(bus8.bitCount), 32'h0);
        chk("hold_frames", 32'(fd8), 32'h0);

        // LEFT frame, first bit checked three clocks after the rise
        load(16'h0004, 2'b01);
        fd8 = 0; fd16 = 0;
        sin = lbits[7];
        step();
        rise(lbits[7]);
        repeat (3) step();
        chk("left_first_po8", 32'(bus8.parallelOut), 32'h09);
        chk("left_first_so8", 32'(bus8.serialOut), 32'h0);
        step();
        sclk = 1'b0;
        repeat (4) step();
        for (int i = 6; i >= 0; i--) pulse(lbits[i], 4, 4);
        chk("left_po8", 32'(bus8.parallelOut), 32'hB2);
        chk("left_po16", 32'(bus16.parallelOut), 32'h04B2);
        chk("left_frames8", 32'(fd8), 32'h1);
        chk("left_frames16", 32'(fd16), 32'h0);
        chk("left_cnt8", 32'(bus8.bitCount), 32'h0);

        // RIGHT frame
        load(16'h0000, 2'b10);
        fd8 = 0;
        for (int i = 0; i < 8; i++) pulse(rbits[i], 4, 4);
        chk("right_po8", 32'(bus8.parallelOut), 32'h15);
        chk("right_po16", 32'(bus16.parallelOut), 32'h1500);
        chk("right_frames8", 32'(fd8), 32'h1);

        // PLOAD on the very edge a shift event at bitCount=5 would land
        load(16'h0000, 2'b01);
        repeat (5) pulse(1'b1, 4, 4);
        chk("bnd_cnt_pre", 32'(bus8.bitCount), 32'h5);
        fd8 = 0; fd16 = 0;
        sin = 1'b1;
        step();
        rise(1'b1);
        step();
        step();
        mode = 2'b11;
        pin  = 16'h3C5A;
        step();
        mode = 2'b01;
        chk("bnd_po8", 32'(bus8.parallelOut), 32'h5A);
        chk("bnd_cnt8", 32'(bus8.bitCount), 32'h0);
        chk("bnd_fd8", 32'(bus8.frameDone), 32'h0);
        step();
        sclk = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 16; i++) pulse(1'(($urandom >> 3) & 1), 4, 4);
        chk("b2b_frames8", 32'(fd8), 32'h2);
        chk("b2b_frames16", 32'(fd16), 32'h1);

        // reset in the middle of a frame drops the partial frame
        repeat (5) pulse(1'b1, 4, 4);
        assert_reset();
        step();
        release_reset();
        step();
        fd8 = 0; fd16 = 0;
        mode = 2'b01;
        repeat (3) pulse(1'b0, 4, 4);
        chk("mid_frames8_at3", 32'(fd8), 32'h0);
        repeat (5) pulse(1'b1, 4, 4);
        chk("mid_frames8_at8", 32'(fd8), 32'h1);
        chk("mid_frames16_at8", 32'(fd16), 32'h0);
        repeat (8) pulse(1'b0, 4, 4);
        chk("mid_frames16_at16", 32'(fd16), 32'h1);
        chk("mid_frames8_at16", 32'(fd8), 32'h2);

        // release while serialClk is already high yields one shift event
        assert_reset();
        sin  = 1'b1;
        sclk = 1'b1;
        step();
        release_reset();
        repeat (5) step();
        chk("rel_high_cnt8", 32'(bus8.bitCount), 32'h1);
        sclk = 1'b0;
        repeat (4) step();

        // randomized modes, data, loads and spacing
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 11));
            if (r == 0) load(16'($urandom), 2'($urandom_range(1, 2)));
            else if (r == 1) mode = 2'b00;
            else if (r == 2) begin
                assert_reset();
                step();
                release_reset();
            end else if (r > 6) mode = 2'($urandom_range(1, 2));
            pulse(1'($urandom & 1), int'($urandom_range(4, 7)), int'($urandom_range(4, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shiftregister_frame.md
# shiftregister_frame

Parametrised serial/parallel shift register with serialClk edge detection in the clk domain, a bit counter, and a frame-complete pulse. It generalises the 8-bit shift register used on the SPI datapath. It adds configurable width, internal synchronisation of serialClk and serialIn, and a per-frame done strobe, so the SPI controller can tell when a whole word has been transferred. It sits between the SPI pins (after any pad logic) and the SPI control FSM / register file.

## Interface
- WIDTH, 8, data width in bits; minimum 2.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.
- clk  input  1  system clock; all state updates on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- serialClk  input  1  SPI serial clock; asynchronous to clk, slow (at least 4 clk periods high and 4 low).
- mode  input  2  operation: 2'b00 HOLD, 2'b01 LEFT (MSB-first), 2'b10 RIGHT (LSB-first), 2'b11 PLOAD.
- parallelIn  input  WIDTH  word loaded on PLOAD.
- serialIn  input  1  serial data; asynchronous, sampled alongside serialClk.
- parallelOut  output  WIDTH  current register contents.
- serialOut  output  1  outgoing bit: parallelOut[WIDTH-1] in LEFT, parallelOut[0] in RIGHT, otherwise holds its last value.
- bitCount  output  CNT_W  shifts completed in the current frame, 0..WIDTH-1.
- frameDone  output  1  one-clk pulse when the WIDTH-th shift of a frame completes.

## Operation
- Synchroniser: serialClk passes through flops sc1, sc2, sc3. The shift event is sc2 & ~sc3. serialIn passes through matching flops si1, si2, and si2 is the bit shifted in, so data and clock stay aligned.
- PLOAD: on every clk edge while mode==PLOAD, parallelOut<=parallelIn and bitCount<=0. Shift events are ignored. PLOAD does not wait for serialClk.
- HOLD: parallelOut, bitCount and serialOut are unchanged. Shift events are discarded, not queued.
- LEFT, on a shift event: parallelOut <= {parallelOut[WIDTH-2:0], si2}.
- RIGHT, on a shift event: parallelOut <= {si2, parallelOut[WIDTH-1:1]}.
- bitCount on a shift event in LEFT or RIGHT:
  - increments;
  - when it would reach WIDTH, it wraps to 0 and frameDone is asserted for exactly that one clk cycle.
- serialOut is registered. It is updated every clk cycle in LEFT/RIGHT from the post-update register (the MSB/LSB selection above). In HOLD/PLOAD it keeps its last value.
- Priority: PLOAD over a simultaneous shift event. That shift is lost and bitCount goes to 0.
- Mode change in the middle of a frame: bitCount is not cleared. Only PLOAD and reset clear it.
- Back-to-back frames: a shift event on the cycle after a wrap counts as bit 1 of the next frame, with no dead cycle.

## Timing
- Reset (resetN low, asynchronous): parallelOut=0, serialOut=0, bitCount=0, frameDone=0. sc1..sc3 and si1..si2 are cleared to 0.
- Deassertion of resetN is effective on the next clk rising edge. If serialClk is already high at deassertion, it produces one shift event 2 cycles later; this is required and documented behaviour.
- Latency: serialClk rising before clk edge k gives:
  - sc1 updates at k;
  - sc2 updates at k+1, and the event is high in cycle k+1..k+2;
  - parallelOut, bitCount and serialOut update at edge k+2;
  - frameDone is high from k+2 to k+3.
- serialIn must be stable from at least 1 clk before to 1 clk after the serialClk rising edge.
- PLOAD latency: 1 clk, from mode/parallelIn set up before edge k to parallelOut valid after edge k.
- Reset asserted mid-frame: everything clears immediately and the partial frame is lost. frameDone is not asserted.
- serialClk falling edges cause no state change.

## Test plan
- Reset: hold resetN=0 with parallelIn=8'hFF, mode=PLOAD, toggling serialClk -> parallelOut=0, serialOut=0, bitCount=0, frameDone=0 throughout.
- PLOAD/HOLD: PLOAD 8'hA5 then HOLD, apply 8 serialClk pulses with serialIn=1 -> parallelOut stays 8'hA5, bitCount=0, no frameDone.
- LEFT frame: PLOAD 8'h04, LEFT, serialIn bits 1,0,1,1,0,0,1,0 on 8 serialClk rises:
  - after the 1st shift: parallelOut=8'h09 and serialOut=0, 3 clk after the serialClk rise;
  - final parallelOut=8'hB2;
  - frameDone is a single pulse on the 8th shift; bitCount reads 0 afterwards.
- RIGHT frame: PLOAD 8'h00, RIGHT, serialIn 1,0,1,0,1,0,0,0 -> parallelOut=8'h15, serialOut tracks bit0 each shift, frameDone is pulsed once.
- Boundary: PLOAD asserted on the same cycle as a shift event at bitCount=5 -> parallelOut=parallelIn, bitCount=0, no frameDone. Then 16 back-to-back shifts -> exactly two frameDone pulses.
- Mid-frame reset: after 5 LEFT shifts, pulse resetN low -> all outputs 0 immediately; the next 8 shifts produce frameDone on the 8th, not the 3rd. Repeat with WIDTH=16: frameDone after the 16th shift only.
